// File: rtl/hazard_sb_pkg.sv
// Shared types and constants for the scoreboard/hazard unit.
//   sb_state_t : trap sequencing states (run, drain long-latency ops, flush)
//   regidx_t   : architectural register index for the default 32-register file
//   fu_id_t    : functional-unit id for the default two-FU configuration
//   FU_MEM / FU_MULDIV : ids of the data-memory and multiply/divide units
package hazard_sb_pkg;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_FLUSH
  } sb_state_t;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FU_ID_W   = 1;

  typedef logic [REG_IDX_W-1:0] regidx_t;
  typedef logic [FU_ID_W-1:0]   fu_id_t;

  localparam fu_id_t FU_MEM    = 1'b0;
  localparam fu_id_t FU_MULDIV = 1'b1;

endpackage

// File: rtl/sb_fu_counter.sv
// In-flight operation counter for one long-latency functional unit.
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   inc         an op was issued to this FU
//   dec         the FU writes back this cycle
//   count       registered in-flight count
//   count_next  count after this cycle's inc/dec
//   full        count == MAX_OUT
//   empty       count == 0
//   underflow   dec seen with nothing in flight (ignored)
module sb_fu_counter #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  logic dec_ok;
  logic inc_ok;

  always_comb begin
    full      = (count == CW'(MAX_OUT));
    empty     = (count == '0);
    underflow = dec && empty;
    dec_ok    = dec && !empty;
    // A same-cycle retire frees the slot, so a full counter may still accept.
    inc_ok    = inc && (!full || dec_ok);
    count_next = count;
    if (inc_ok && !dec_ok) begin
      count_next = count + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard and hazard controller for pipelines with long-latency FUs.
// Tracks pending register writes, stalls issue on RAW/WAW hazards or a full FU,
// and sequences traps through DRAIN/FLUSH so in-flight long ops retire first.
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   issue_valid/issue_ready    issue handshake (fires on valid && ready)
//   issue_rs, issue_rs_use     packed source regs and their used flags
//   issue_rd, issue_wen        destination reg and write enable
//   issue_long, issue_fu       long-latency routing and target FU id
//   wb_valid, wb_rd            per-FU writeback strobe and destination
//   br_flush                   branch redirect from execute
//   trap_req / trap_ack        trap request level / one-cycle redirect pulse
//   pipe_flush, draining       flush younger stages / FSM in DRAIN
//   pending, outstanding       scoreboard bits / packed per-FU in-flight counts
// Build option: SCOREBOARD_WB_BYPASS_EN lets this cycle's writebacks clear
// hazards and count toward drain completion in the same cycle.
module scoreboard_hazard_unit
  import hazard_sb_pkg::*;
#(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned NFU     = 2,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned RW = $clog2(NREGS),
  localparam int unsigned FW = (NFU > 1) ? $clog2(NFU) : 1,
  localparam int unsigned CW = $clog2(MAX_OUT + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [NSRC*RW-1:0] issue_rs,
  input  logic [NSRC-1:0]    issue_rs_use,
  input  logic [RW-1:0]      issue_rd,
  input  logic               issue_wen,
  input  logic               issue_long,
  input  logic [FW-1:0]      issue_fu,
  input  logic [NFU-1:0]     wb_valid,
  input  logic [NFU*RW-1:0]  wb_rd,
  input  logic               br_flush,
  input  logic               trap_req,
  output logic               trap_ack,
  output logic               pipe_flush,
  output logic               draining,
  output logic [NREGS-1:0]   pending,
  output logic [NFU*CW-1:0]  outstanding
);

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  sb_state_t state_q, state_d;

  logic [NREGS-1:0] pending_d, set_mask, clr_mask, pend_haz;
  logic [NFU-1:0]   fu_inc, fu_full, fu_empty, fu_underflow, wb_ok;
  logic [CW-1:0]    cnt_q    [NFU];
  logic [CW-1:0]    cnt_next [NFU];
  logic             raw, waw, full_hit, fire, all_empty, all_next_zero, drain_done;

  for (genvar f = 0; f < NFU; f++) begin : g_fu
    sb_fu_counter #(
      .MAX_OUT (MAX_OUT),
      .CW      (CW)
    ) u_cnt (
      .CLK        (CLK),
      .nRST       (nRST),
      .inc        (fu_inc[f]),
      .dec        (wb_valid[f]),
      .count      (cnt_q[f]),
      .count_next (cnt_next[f]),
      .full       (fu_full[f]),
      .empty      (fu_empty[f]),
      .underflow  (fu_underflow[f])
    );
    assign outstanding[f*CW +: CW] = cnt_q[f];

    // A stray writeback (nothing in flight) must never move the counter.
    a_stray_wb_ignored : assert property (@(posedge CLK) disable iff (!nRST)
      fu_underflow[f] |-> (cnt_next[f] == CW'(fu_inc[f])));
  end

  // Hazard detection and scoreboard next state.
  always_comb begin
    wb_ok    = wb_valid & ~fu_empty;
    clr_mask = '0;
    for (int f = 0; f < NFU; f++) begin
      if (wb_ok[f]) clr_mask[wb_rd[f*RW +: RW]] = 1'b1;
    end
    pend_haz = Bypass ? (pending & ~clr_mask) : pending;

    raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (issue_rs_use[i] && (issue_rs[i*RW +: RW] != '0) && pend_haz[issue_rs[i*RW +: RW]]) begin
        raw = 1'b1;
      end
    end
    waw = issue_wen && pend_haz[issue_rd];

    full_hit = 1'b0;
    for (int f = 0; f < NFU; f++) begin
      if (issue_long && (issue_fu == FW'(f)) && fu_full[f] && !wb_ok[f]) full_hit = 1'b1;
    end

    issue_ready = (state_q == SB_RUN) && !trap_req && !br_flush && !raw && !waw && !full_hit;
    fire        = issue_valid && issue_ready;

    fu_inc = '0;
    for (int f = 0; f < NFU; f++) begin
      if (fire && issue_long && (issue_fu == FW'(f))) fu_inc[f] = 1'b1;
    end

    set_mask = '0;
    if (fire && issue_long && issue_wen && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;
    // Set wins over a same-cycle clear of the same register.
    pending_d    = (pending & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    all_empty     = &fu_empty;
    all_next_zero = 1'b1;
    for (int f = 0; f < NFU; f++) begin
      if (cnt_next[f] != '0) all_next_zero = 1'b0;
    end
    drain_done = Bypass ? all_next_zero : all_empty;
  end

  // Trap sequencing FSM.
  always_comb begin
    state_d    = state_q;
    pipe_flush = 1'b0;
    trap_ack   = 1'b0;
    draining   = 1'b0;
    unique case (state_q)
      SB_RUN: begin
        pipe_flush = br_flush;
        if (trap_req) state_d = all_empty ? SB_FLUSH : SB_DRAIN;
      end
      SB_DRAIN: begin
        // trap_req may drop here; the trap is already committed.
        draining = 1'b1;
        if (drain_done) state_d = SB_FLUSH;
      end
      SB_FLUSH: begin
        pipe_flush = 1'b1;
        trap_ack   = 1'b1;
        state_d    = SB_RUN;
      end
      default: state_d = SB_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= SB_RUN;
      pending <= '0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
    end
  end

endmodule
